adbg_crc32_rx_check: RTL and testbench
======================================

ADBG_CRC32_RX_CHECK -- requirements
Module: adbg_crc32_rx_check

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of frame data-bit count.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle strobe opening a frame.
REQ-005 SHALL have port len  input  LEN_W  number of data bits in frame, sampled on start.
REQ-006 SHALL have port abort  input  1  cancels frame, returns to IDLE.
REQ-007 SHALL have port bit_valid  input  1  bit_in qualifier, one bit per asserted cycle.
REQ-008 SHALL have port bit_in  input  1  serial frame bit: data bits, then 32 CRC bits LSB first.
REQ-009 SHALL have port busy  output  1  high in DATA or CHECK state.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-011 SHALL have port crc_ok  output  1  received CRC matched; held until next start/abort/rst.
REQ-012 SHALL have port crc_err  output  1  received CRC mismatched; held until next start/abort/rst.
REQ-013 SHALL have port crc_calc  output  32  CRC computed over data bits, captured at end of DATA.

Function
REQ-014 SHALL implement states IDLE, DATA, CHECK, DONE; all outputs registered.
REQ-015 SHALL, on start in any state, load crc=32'hFFFFFFFF, cnt=len, clear crc_ok/crc_err/mismatch, enter DATA (len!=0) or CHECK with cnt=32 and crc_calc=32'hFFFFFFFF (len==0).
REQ-016 SHALL, in DATA on bit_valid, compute fb=crc[0]^bit_in, crc=(crc>>1)^(fb?32'hEDB88320:0), cnt=cnt-1.
REQ-017 SHALL, on the DATA bit where cnt==1, enter CHECK next cycle with cnt=32 and crc_calc=updated crc.
REQ-018 SHALL, in CHECK on bit_valid, set mismatch if bit_in!=crc[0], shift crc={1'b0,crc[31:1]}, cnt=cnt-1.
REQ-019 SHALL, on the CHECK bit where cnt==1, enter DONE; mismatch evaluation includes that final bit.
REQ-020 SHALL, in DONE, assert done for exactly one cycle, set crc_ok=!mismatch, crc_err=mismatch, then enter IDLE.
REQ-021 SHALL never assert crc_ok and crc_err together; both low while busy.
REQ-022 SHALL ignore bit_valid in IDLE and DONE; cycles without bit_valid hold all state.
REQ-023 SHALL give start priority over abort, abort over bit_valid in the same cycle; start while busy restarts frame with no done pulse.
REQ-024 SHALL, on abort while busy, enter IDLE next cycle, done stays low, crc_ok/crc_err stay low.
REQ-025 SHALL accept back-to-back bit_valid every cycle; done of frame N may coincide with start of frame N+1 (start wins, done still pulses).
REQ-026 SHALL use no final XOR and no bit reversal beyond LSB-first serial order.

Reset
REQ-027 SHALL, on rst, asynchronously force IDLE, crc=32'hFFFFFFFF, cnt=0, crc_calc=32'hFFFFFFFF, busy=0, done=0, crc_ok=0, crc_err=0.
REQ-028 SHALL, on rst mid-frame, discard the frame with no done pulse; first post-reset frame needs a new start.

Verification
REQ-029 SHALL test: start len=72, ASCII "123456789" each byte LSB first, then 32'h340BC6D9 LSB first -> crc_calc=32'h340BC6D9, one done pulse, crc_ok=1, crc_err=0.
REQ-030 SHALL test: same frame with CRC bit 31 inverted -> done pulse, crc_ok=0, crc_err=1.
REQ-031 SHALL test: start len=0, 32 ones -> crc_calc=32'hFFFFFFFF, crc_ok=1; 31 ones plus a zero -> crc_err=1.
REQ-032 SHALL test: frame of REQ-029 with random bit_valid gaps -> identical result to gapless run.
REQ-033 SHALL test: abort after 40 data bits, then rst mid-CHECK of a new frame -> no done pulse, busy=0, outputs at reset values.
REQ-034 SHALL test: start asserted on the DONE cycle of a passing frame -> done pulses once, crc_ok cleared next cycle, new frame checks correctly.

Source files
------------

// File: rtl/adbg_crc32_rx_check.sv
// Serial CRC-32 receive checker.
// A frame is `len` data bits followed by 32 CRC bits, all LSB first.
// The data bits are folded into a reflected CRC-32 (poly 0xEDB88320,
// init 0xFFFFFFFF, no final XOR). The trailing CRC bits are then compared
// one by one against the running remainder. The verdict appears as a
// one-cycle done pulse, together with sticky crc_ok / crc_err flags.
module adbg_crc32_rx_check #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [31:0]      crc_calc
);

    // The counter must also be able to hold 32 for the CHECK phase.
    localparam int CNT_W = (LEN_W > 6) ? LEN_W : 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [31:0]      crc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             mismatch_r;

    logic [31:0]      crc_next_s;
    logic             bit_mm_s;
    logic             cnt_last_s;
    logic             mm_final_s;

    // One LSB-first step of the reflected CRC-32 shift register.
    function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0000_0000);
    endfunction

    // Next-state helpers: CRC update, per-bit compare, last-bit detect.
    always_comb begin
        crc_next_s = crc32_step(crc_r, bit_in);
        bit_mm_s   = bit_in ^ crc_r[0];
        cnt_last_s = (cnt_r == CNT_W'(1));
        mm_final_s = mismatch_r | bit_mm_s;
    end

    // Frame-control FSM. All state and outputs are registered here.
    // Priority within a cycle: start, then abort, then bit_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            crc_r      <= 32'hFFFF_FFFF;
            cnt_r      <= {CNT_W{1'b0}};
            mismatch_r <= 1'b0;
            crc_calc   <= 32'hFFFF_FFFF;
            busy       <= 1'b0;
            done       <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A restart abandons any frame in flight without a done pulse.
                crc_r      <= 32'hFFFF_FFFF;
                mismatch_r <= 1'b0;
                crc_ok     <= 1'b0;
                crc_err    <= 1'b0;
                busy       <= 1'b1;
                if (len == {LEN_W{1'b0}}) begin
                    // Empty payload: the expected CRC is the initial value.
                    state_r  <= CHECK;
                    cnt_r    <= CNT_W'(32);
                    crc_calc <= 32'hFFFF_FFFF;
                end else begin
                    state_r <= DATA;
                    cnt_r   <= CNT_W'(len);
                end
            end else if (abort) begin
                state_r <= IDLE;
                busy    <= 1'b0;
                crc_ok  <= 1'b0;
                crc_err <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    DATA: begin
                        if (bit_valid) begin
                            crc_r <= crc_next_s;
                            if (cnt_last_s) begin
                                state_r  <= CHECK;
                                cnt_r    <= CNT_W'(32);
                                crc_calc <= crc_next_s;
                            end else begin
                                cnt_r <= cnt_r - CNT_W'(1);
                            end
                        end
                    end
                    CHECK: begin
                        if (bit_valid) begin
                            mismatch_r <= mm_final_s;
                            crc_r      <= {1'b0, crc_r[31:1]};
                            cnt_r      <= cnt_r - CNT_W'(1);
                            if (cnt_last_s) begin
                                // The verdict includes the final CRC bit and is
                                // visible in the same cycle as the done pulse.
                                state_r <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                crc_ok  <= ~mm_final_s;
                                crc_err <= mm_final_s;
                            end
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adbg_crc32_rx_check.sv
// Scoreboard bench for adbg_crc32_rx_check.
// Each frame that should complete pushes its expected verdict when it starts.
// A negedge monitor pops the verdict on every done pulse and compares it.
module tb_adbg_crc32_rx_check;

    localparam int LEN_W = 16;
    localparam logic [71:0] MSG   = 72'h39_38_37_36_35_34_33_32_31; // "123456789", byte 0 in [7:0]
    localparam logic [31:0] CHECK = 32'h340BC6D9;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             bit_valid;
    logic             bit_in;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic             crc_err;
    logic [31:0]      crc_calc;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] calc;
        logic        ok;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    adbg_crc32_rx_check #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .crc_calc  (crc_calc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: enforce flag exclusivity and score every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            chk("flags_excl", {30'd0, crc_ok & crc_err, busy & (crc_ok | crc_err)}, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("crc_calc", crc_calc, e.calc);
                    chk("crc_ok", {31'd0, crc_ok}, {31'd0, e.ok});
                    chk("crc_err", {31'd0, crc_err}, {31'd0, e.err});
                end
            end
        end
    end

    // Each task below starts #1 after a rising edge and returns at the same point.
    task automatic idle_cycle();
        bit_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drive_bit(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [LEN_W-1:0] n);
        start = 1'b1;
        len   = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [LEN_W-1:0] n, input logic [71:0] data,
                              input logic [31:0] crc, input bit gaps,
                              input logic [31:0] e_calc, input logic e_ok, input bit chk_clr);
        exp_t e;
        e.calc = e_calc;
        e.ok   = e_ok;
        e.err  = ~e_ok;
        exp_q.push_back(e);
        start_frame(n);
        if (chk_clr) begin
            chk("clr_ok_on_restart", {31'd0, crc_ok}, 32'd0);
            chk("busy_on_restart", {31'd0, busy}, 32'd1);
        end
        for (int k = 0; k < int'(n); k++) drive_bit(data[k], gaps);
        for (int k = 0; k < 32; k++) drive_bit(crc[k], gaps);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) idle_cycle();
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {30'd0, crc_ok, crc_err}, 32'd0);
        chk("rst_calc", crc_calc, 32'hFFFF_FFFF);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer frame, then the same frame with CRC bit 31 flipped.
        send_frame(16'd72, MSG, CHECK, 1'b0, CHECK, 1'b1, 1'b0);
        wait_drain();
        send_frame(16'd72, MSG, CHECK ^ 32'h8000_0000, 1'b0, CHECK, 1'b0, 1'b0);
        wait_drain();

        // Empty payload: the expected CRC is all ones.
        send_frame(16'd0, 72'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_drain();
        send_frame(16'd0, 72'd0, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_drain();

        // Random bit_valid gaps must not change the result.
        send_frame(16'd72, MSG, CHECK, 1'b1, CHECK, 1'b1, 1'b0);
        wait_drain();
        send_frame(16'd72, MSG, CHECK ^ 32'h0000_0100, 1'b1, CHECK, 1'b0, 1'b0);
        wait_drain();

        // Abort after 40 data bits; the monitor flags any done pulse.
        start_frame(16'd72);
        for (int k = 0; k < 40; k++) drive_bit(MSG[k], 1'b0);
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; bit_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_flags", {30'd0, crc_ok, crc_err}, 32'd0);
        repeat (3) idle_cycle();

        // Reset in the middle of the CHECK phase of a new frame.
        start_frame(16'd8);
        for (int k = 0; k < 8; k++) drive_bit(MSG[k], 1'b0);
        for (int k = 0; k < 10; k++) drive_bit(1'b1, 1'b0);
        chk("busy_mid_check", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_flags", {30'd0, crc_ok, crc_err}, 32'd0);
        chk("arst_calc", crc_calc, 32'hFFFF_FFFF);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        // Bits without a start must be ignored.
        for (int k = 0; k < 40; k++) drive_bit(1'b1, 1'b0);
        chk("no_start_busy", {31'd0, busy}, 32'd0);

        // Start on the DONE cycle of a passing frame.
        send_frame(16'd72, MSG, CHECK, 1'b0, CHECK, 1'b1, 1'b0);
        chk("done_cycle_ok", {31'd0, crc_ok}, 32'd1);
        send_frame(16'd72, MSG, CHECK, 1'b0, CHECK, 1'b1, 1'b1);
        wait_drain();
        repeat (3) idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
